// File: rtl/cmp_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmp_iter : multi-cycle chunked equality / less-than comparator, MSB chunk first
// Optional: CMP_EARLY_EXIT_EN stops at the first differing chunk
// Revision : 1.0
// ----------------------------------------------------------------------------
module cmp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [2:0]       function_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef CMP_EARLY_EXIT_EN
  localparam logic EARLY_EXIT = 1'b1;
`else
  localparam logic EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_a_nxt;
  logic [WIDTH-1:0] op_b, op_b_nxt;
  logic [2:0]       fs, fs_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             decided, decided_nxt;
  logic             eq, eq_nxt;
  logic             lt, lt_nxt;
  logic [WIDTH-1:0] sign_flip;
  logic [CHUNK-1:0] chunk_a, chunk_b;

  // Flipping both sign bits maps signed order onto unsigned order.
  assign sign_flip = function_select[1] ? '0 : SIGN_MASK;
  assign chunk_a   = op_a[idx*CHUNK +: CHUNK];
  assign chunk_b   = op_b[idx*CHUNK +: CHUNK];

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign result    = (state == DONE) && (fs[0] ^ (fs[2] ? lt : eq));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      fs      <= '0;
      idx     <= '0;
      decided <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_a    <= op_a_nxt;
      op_b    <= op_b_nxt;
      fs      <= fs_nxt;
      idx     <= idx_nxt;
      decided <= decided_nxt;
      eq      <= eq_nxt;
      lt      <= lt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_a_nxt    = op_a;
    op_b_nxt    = op_b;
    fs_nxt      = fs;
    idx_nxt     = idx;
    decided_nxt = decided;
    eq_nxt      = eq;
    lt_nxt      = lt;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_a_nxt    = input_a ^ sign_flip;
          op_b_nxt    = input_b ^ sign_flip;
          fs_nxt      = function_select;
          idx_nxt     = LAST_IDX;
          decided_nxt = 1'b0;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        // Only the most significant differing chunk decides the outcome.
        if (!decided && (chunk_a != chunk_b)) begin
          eq_nxt      = 1'b0;
          lt_nxt      = (chunk_a < chunk_b);
          decided_nxt = 1'b1;
        end
        if (idx == '0 && !decided_nxt) begin
          eq_nxt = 1'b1;
          lt_nxt = 1'b0;
        end
        if (idx == '0 || (EARLY_EXIT && decided_nxt)) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cmp_iter.sv
`default_nettype none
// Randomized and directed bench for cmp_iter against a behavioural model.
module tb_cmp_iter;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NC    = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  input_a;
  logic [WIDTH-1:0]  input_b;
  logic [2:0]        function_select;
  logic              out_valid;
  logic              out_ready;
  logic              result;

  int n_checks = 0;
  int n_errors = 0;

  cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .input_a         (input_a),
    .input_b         (input_b),
    .function_select (function_select),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .result          (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] f);
    logic r;
    if (f[2]) r = f[1] ? (a < b) : ($signed(a) < $signed(b));
    else      r = (a == b);
    return r ^ f[0];
  endfunction

  // Cycles from the accept cycle (index 0) to the first cycle with out_valid.
  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int busy;
    busy = NC;
    for (int k = 0; k < NC; k++)
      if (a[k*CHUNK +: CHUNK] != b[k*CHUNK +: CHUNK]) busy = NC - k;
`ifndef CMP_EARLY_EXIT_EN
    busy = NC;
`endif
    return busy + 1;
  endfunction

  task automatic start_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [2:0] f);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    input_a = a; input_b = b; function_select = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    input_a = $urandom; input_b = $urandom; function_select = 3'($urandom);
  endtask

  task automatic op_check(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] f, input int stall, input logic exp_res, input int exp_lat);
    int lat;
    logic held;
    out_ready = 1'b0;
    start_op(tag, a, b, f);
    lat = 1;
    while (!out_valid && lat < NC + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    held = result;
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      input_a = $urandom; input_b = $urandom;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_res"}, 32'(result), 32'(held));
      check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [2:0] f;
    int lat_lt;
`ifdef CMP_EARLY_EXIT_EN
    lat_lt = 2;
`else
    lat_lt = 5;
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    input_a = '0; input_b = '0; function_select = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    op_check("eq",      32'h00000005, 32'h00000005, 3'b000, 0, 1'b1, 5);
    op_check("neq",     32'h00000005, 32'h00000005, 3'b001, 0, 1'b0, 5);
    op_check("slt",     32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1'b1, lat_lt);
    op_check("ult",     32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 1'b0, lat_lt);
    op_check("uge",     32'hFFFFFFFF, 32'h00000001, 3'b111, 0, 1'b1, lat_lt);
    op_check("ult_c0",  32'h12345600, 32'h12345601, 3'b110, 0, 1'b1, 5);
    op_check("bp",      32'hFFFFFFFF, 32'h00000001, 3'b100, 6, 1'b1, lat_lt);

    // Reset during the second BUSY cycle abandons the operation.
    start_op("rst_mid", 32'h80000000, 32'h00000000, 3'b100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", 32'(result), 32'd0);
    check("rst_mid_rdy", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdy_after", 32'(in_ready), 32'd1);
    op_check("rst_redo", 32'h80000000, 32'h00000000, 3'b100, 0, 1'b1,
             model_lat(32'h80000000, 32'h00000000));

    op_check("smin_lt", 32'h80000000, 32'h7FFFFFFF, 3'b100, 0, 1'b1,
             model_lat(32'h80000000, 32'h7FFFFFFF));
    op_check("smin_ult", 32'h80000000, 32'h7FFFFFFF, 3'b110, 0, 1'b0,
             model_lat(32'h80000000, 32'h7FFFFFFF));
    op_check("ueq_fs2", 32'hDEADBEEF, 32'hDEADBEEF, 3'b010, 0, 1'b1, 5);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, WIDTH - 1));
        2:       b = {a[31:16], 16'($urandom)};
        default: b = $urandom;
      endcase
      f = 3'($urandom);
      op_check("rand", a, b, f, $urandom_range(0, 3), model_res(a, b, f), model_lat(a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmp_iter.md
Name: cmp_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch/SLT comparator in the execute stage.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, so wide datapaths (64/128-bit) meet timing.
- Valid/ready handshakes on input and output let the issue logic stall on it like any other multi-cycle unit.
- Keeps the existing 3-bit function_select encoding.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle; must divide WIDTH exactly.
- NUM_CHUNKS, WIDTH/CHUNK, derived localparam; not overridable.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and function_select valid
- in_ready  output  1  unit can accept a new operation
- input_a  input  WIDTH  operand A
- input_b  input  WIDTH  operand B
- function_select  input  3  [0] negate result, [1] unsigned, [2] less-than (0 = equality)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- result  output  1  comparison outcome

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low. rst_n sampled low at a clk edge sets state IDLE, out_valid 0, result 0, chunk index 0 and the decided flag cleared.
  - in_ready is 0 while rst_n is low, and 1 in the cycle after reset is released.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register input_a, input_b and function_select; set idx = NUM_CHUNKS-1; clear decided; go to BUSY.
- BUSY (in_ready = 0, out_valid = 0):
  - Each cycle compare chunk idx of A and B.
  - Signed mode (fs[1] = 0): invert bit WIDTH-1 of both operands before chunk compare. The top chunk is then ordered correctly as unsigned.
  - Chunks differ and not yet decided: record eq = 0, lt = (a_chunk < b_chunk), set decided.
  - Termination with early exit: go to DONE when decided or idx == 0.
  - All chunks equal at idx == 0: eq = 1, lt = 0.
  - Otherwise decrement idx and stay in BUSY.
- DONE:
  - out_valid = 1 and result = fs[0] XOR (fs[2] ? lt : eq).
  - result and out_valid stay stable until out_ready is sampled 1, then go to IDLE.
  - A new operation is not accepted in the same cycle; in_ready rises in IDLE.
- Latency:
  - Accept edge to out_valid is between 2 and NUM_CHUNKS+1 cycles.
  - Throughput is at most one op per latency+1 cycles.
- Equality ignores fs[1].
- fs = 3'b010/011 (unsigned equality) behaves identically to 000/001.
- in_valid while not in IDLE is ignored; the operands are not captured.
- Reset in any state abandons the operation. No output is produced for it.
- NUM_CHUNKS = 1 is legal: a single BUSY cycle, equivalent to the one-cycle comparator plus handshake.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: BUSY leaves at the first differing chunk, giving data-dependent latency.
- Undefined:
  - BUSY always walks all NUM_CHUNKS chunks down to idx 0.
  - The first difference is still latched via the decided flag; later chunks do not overwrite eq/lt.
  - Latency is fixed at NUM_CHUNKS+1 cycles from accept to out_valid, for constant-time operation.
- Result values are identical with and without the macro.

Test Plan (WIDTH=32, CHUNK=8):
- Equality: a=0x00000005, b=0x00000005, fs=000 -> result=1; out_valid 5 cycles after accept edge (4 BUSY cycles). Same operands with fs=001 -> result=0.
- Signed less-than: a=0xFFFFFFFF, b=0x00000001, fs=100 -> result=1.
  - With CMP_EARLY_EXIT_EN, out_valid 2 cycles after accept.
  - Without it, out_valid 5 cycles after accept.
- Unsigned less-than: same operands, fs=110 -> result=0; fs=111 -> result=1. Also a=0x12345600, b=0x12345601, fs=110 -> result=1, decided on chunk 0.
- Backpressure: complete an op, hold out_ready=0 for 6 cycles.
  - out_valid=1 and result unchanged throughout; in_ready=0; a pulsed in_valid is ignored.
  - Then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Reset mid-operation: accept a=0x80000000, b=0, fs=100, then drive rst_n=0 during the second BUSY cycle.
  - Next cycle: out_valid=0, result=0, state IDLE; in_ready=1 the cycle after rst_n returns high.
  - A fresh op with the same operands completes with result=1.
- Signed boundary: a=0x80000000, b=0x7FFFFFFF, fs=100 -> result=1; with fs=110 -> result=0.
